fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Owns the PC, issues one instruction request at a time on the instruction cache bus (`ibus_req_t`/`ibus_resp_t`) and delivers fetched instructions to decode through the `REG_IF_ID` pipeline register. Handles decode back-pressure with a one-entry skid buffer and handles redirects (branches/flushes) from later stages, including squashing an in-flight bus request.

---
 rtl/common_pkg.sv | 26 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared pipeline types: instruction bus structs, IF/ID register layout and fetch FSM states.
package common;

  localparam logic [63:0] PCINIT = 64'h8000_0000;

  typedef enum logic [1:0] {BOOT, FETCH, SQUASH, HOLD} fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pcPlus4;
    logic [31:0] instr;
    logic [63:0] instrAddr;
  } REG_IF_ID;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one bus request in flight, feeds decode through
// if_id with a one-entry skid buffer, and squashes in-flight requests on redirect.
module fetch_stage
  import common::*;
#(
  parameter logic [63:0] PC_INIT = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output REG_IF_ID    if_id
);

  fetch_state_t state_reg;
  logic [63:0]  pc_reg;
  logic [63:0]  req_addr_reg;
  REG_IF_ID     buf_reg;
  REG_IF_ID     if_id_reg;

  logic [63:0]  target;
  logic [63:0]  seq_addr;
  logic         consumed;
  REG_IF_ID     fetched;
  logic         unused_bits;

  // addr_ok is not part of the handshake; the low target bits are forced to zero.
  assign unused_bits = iresp.addr_ok ^ redirect_pc[1] ^ redirect_pc[0];

  assign target   = {redirect_pc[63:2], 2'b00};
  assign seq_addr = req_addr_reg + 64'd4;
  assign consumed = if_id_reg.valid && !stall;

  always_comb begin
    fetched           = '0;
    fetched.valid     = 1'b1;
    fetched.instr     = iresp.data;
    fetched.instrAddr = req_addr_reg;
    fetched.pcPlus4   = seq_addr;
  end

  always_comb begin
    ireq       = '0;
    ireq.valid = (state_reg == FETCH) || (state_reg == SQUASH);
    ireq.addr  = req_addr_reg;
  end

  assign if_id = if_id_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= PC_INIT;
      req_addr_reg <= PC_INIT;
      buf_reg      <= '0;
      if_id_reg    <= '0;
    end else if (redirect_valid) begin
      pc_reg          <= target;
      if_id_reg.valid <= 1'b0;
      buf_reg.valid   <= 1'b0;
      case (state_reg)
        // An unfinished request must still complete on the bus, so it is squashed instead.
        FETCH: begin
          if (iresp.data_ok) req_addr_reg <= target;
          else               state_reg    <= SQUASH;
        end
        SQUASH: begin
          if (iresp.data_ok) begin
            req_addr_reg <= target;
            state_reg    <= FETCH;
          end
        end
        default: begin
          req_addr_reg <= target;
          state_reg    <= FETCH;
        end
      endcase
    end else begin
      if (consumed) if_id_reg.valid <= 1'b0;
      case (state_reg)
        BOOT: begin
          req_addr_reg <= pc_reg;
          state_reg    <= FETCH;
        end
        FETCH: begin
          if (iresp.data_ok) begin
            if (!if_id_reg.valid || !stall) begin
              if_id_reg <= fetched;
            end else begin
              buf_reg   <= fetched;
              state_reg <= HOLD;
            end
            pc_reg       <= seq_addr;
            req_addr_reg <= seq_addr;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_reg     <= buf_reg;
            buf_reg.valid <= 1'b0;
            req_addr_reg  <= pc_reg;
            state_reg     <= FETCH;
          end
        end
        SQUASH: begin
          if (iresp.data_ok) begin
            req_addr_reg <= pc_reg;
            state_reg    <= FETCH;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based behavioural model.
module tb_fetch_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  REG_IF_ID    if_id;

  always #5 clk = ~clk;

  fetch_stage #(.PC_INIT(64'h8000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .ireq(ireq),
    .iresp(iresp),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_id(if_id)
  );

  // Model: started = past the boot cycle, drop = a response is owed but must be discarded,
  // skid queue non-empty = decode is full and one fetched word is parked.
  bit          m_started;
  bit          m_drop;
  logic [63:0] m_pc;
  logic [63:0] m_req;
  REG_IF_ID    m_if;
  REG_IF_ID    m_skid[$];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_started = 1'b0;
    m_drop    = 1'b0;
    m_pc      = 64'h8000_0000;
    m_req     = 64'h8000_0000;
    m_if      = '0;
    m_skid.delete();
  endfunction

  function automatic void model_step();
    REG_IF_ID    e;
    logic [63:0] tgt;
    bit          held, dok, was_valid;
    if (reset) begin
      model_reset();
      return;
    end
    tgt       = redirect_pc & ~64'h3;
    held      = m_skid.size() != 0;
    dok       = m_started && !held && iresp.data_ok;
    was_valid = m_if.valid;
    if (!m_started) begin
      m_started = 1'b1;
      if (redirect_valid) begin
        m_pc       = tgt;
        m_if.valid = 1'b0;
      end
      m_req = m_pc;
      return;
    end
    if (redirect_valid) begin
      m_pc       = tgt;
      m_if.valid = 1'b0;
      m_skid.delete();
      if (held) m_req = tgt;
      else if (m_drop) begin
        if (dok) begin
          m_drop = 1'b0;
          m_req  = tgt;
        end
      end else if (dok) m_req = tgt;
      else m_drop = 1'b1;
      return;
    end
    if (was_valid && !stall) m_if.valid = 1'b0;
    if (held) begin
      if (!stall) begin
        m_if  = m_skid.pop_front();
        m_req = m_pc;
      end
    end else if (m_drop) begin
      if (dok) begin
        m_drop = 1'b0;
        m_req  = m_pc;
      end
    end else if (dok) begin
      e.valid     = 1'b1;
      e.instr     = iresp.data;
      e.instrAddr = m_req;
      e.pcPlus4   = m_req + 64'd4;
      if (!was_valid || !stall) m_if = e;
      else m_skid.push_back(e);
      m_req = m_req + 64'd4;
      m_pc  = m_req;
    end
  endfunction

  // Single compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ireq.valid", 64'(ireq.valid), 64'(m_started && m_skid.size() == 0));
      chk("ireq.addr", ireq.addr, m_req);
      chk("if_id.valid", 64'(if_id.valid), 64'(m_if.valid));
      if (m_if.valid) begin
        chk("if_id.pcPlus4", if_id.pcPlus4, m_if.pcPlus4);
        chk("if_id.instr", 64'(if_id.instr), 64'(m_if.instr));
        chk("if_id.instrAddr", if_id.instrAddr, m_if.instrAddr);
      end
    end
  end

  task automatic drive(input bit st, input bit dok, input logic [31:0] d,
                       input bit rv, input logic [63:0] rpc);
    stall          = st;
    iresp.data_ok  = dok;
    iresp.addr_ok  = dok;
    iresp.data     = d;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_if(input string nm, input logic [63:0] ia, input logic [31:0] ins);
    chk({nm, ".valid"}, 64'(if_id.valid), 64'd1);
    chk({nm, ".instrAddr"}, if_id.instrAddr, ia);
    chk({nm, ".pcPlus4"}, if_id.pcPlus4, ia + 64'd4);
    chk({nm, ".instr"}, 64'(if_id.instr), 64'(ins));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " ireq.valid"}, 64'(ireq.valid), 64'd0);
    chk({nm, " ireq.addr"}, ireq.addr, 64'h8000_0000);
    chk({nm, " if_id nonzero"}, 64'(if_id != '0), 64'd0);
  endtask

  logic [63:0] rp;
  int          r;

  initial begin
    drive(0, 0, 32'h0, 0, 64'h0);
    model_reset();
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // Reset release, zero-wait bus
    reset = 1'b0;
    cycle();
    chk("boot ireq.valid", 64'(ireq.valid), 64'd1);
    chk("boot ireq.addr", ireq.addr, 64'h8000_0000);
    drive(0, 1, 32'h0000_0013, 0, 64'h0);
    cycle();
    chk_if("first", 64'h8000_0000, 32'h0000_0013);
    chk("first next addr", ireq.addr, 64'h8000_0004);
    chk("model req after first", m_req, 64'h8000_0004);

    // Stall while the next word arrives -> parked, no request
    drive(1, 1, 32'h0000_00A3, 0, 64'h0);
    cycle();
    chk("hold ireq.valid", 64'(ireq.valid), 64'd0);
    chk_if("hold if_id", 64'h8000_0000, 32'h0000_0013);
    drive(0, 0, 32'h0, 0, 64'h0);
    cycle();
    chk_if("unhold", 64'h8000_0004, 32'h0000_00A3);
    chk("unhold ireq.valid", 64'(ireq.valid), 64'd1);
    chk("unhold ireq.addr", ireq.addr, 64'h8000_0008);

    // Redirect while a request is outstanding
    drive(0, 0, 32'h0, 1, 64'h8000_1000);
    cycle();
    chk("sq ireq.addr", ireq.addr, 64'h8000_0008);
    chk("sq if_id.valid", 64'(if_id.valid), 64'd0);
    drive(0, 0, 32'h0, 0, 64'h0);
    cycle();
    chk("sq hold addr", ireq.addr, 64'h8000_0008);
    drive(0, 1, 32'h0000_0BAD, 0, 64'h0);
    cycle();
    chk("sq drop if_id.valid", 64'(if_id.valid), 64'd0);
    chk("sq target addr", ireq.addr, 64'h8000_1000);

    // Redirect coincident with data_ok, misaligned target
    drive(0, 1, 32'h0000_BAD2, 1, 64'h8000_1002);
    cycle();
    chk("coinc if_id.valid", 64'(if_id.valid), 64'd0);
    chk("coinc ireq.addr", ireq.addr, 64'h8000_1000);
    drive(0, 1, 32'h0000_0055, 0, 64'h0);
    cycle();
    chk_if("coinc fetch", 64'h8000_1000, 32'h0000_0055);

    // Redirect while parked in HOLD
    drive(1, 1, 32'h0000_0066, 0, 64'h0);
    cycle();
    chk("hold2 ireq.valid", 64'(ireq.valid), 64'd0);
    drive(1, 0, 32'h0, 1, 64'h8000_2000);
    cycle();
    chk("hredir ireq.addr", ireq.addr, 64'h8000_2000);
    chk("hredir if_id.valid", 64'(if_id.valid), 64'd0);
    drive(0, 0, 32'h0, 0, 64'h0);
    cycle();
    chk("hredir no stale", 64'(if_id.valid), 64'd0);
    drive(0, 1, 32'h0000_0077, 0, 64'h0);
    cycle();
    chk_if("hredir fetch", 64'h8000_2000, 32'h0000_0077);

    // Address wrap at the top of the space
    drive(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    drive(0, 1, 32'h0000_0EEE, 0, 64'h0);
    cycle();
    chk("wrap ireq.addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 1, 32'h0000_0099, 0, 64'h0);
    cycle();
    chk("wrap pcPlus4", if_id.pcPlus4, 64'h0);
    chk("wrap instrAddr", if_id.instrAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap next addr", ireq.addr, 64'h0);
    chk("model wrap req", m_req, 64'h0);

    // Async reset in the middle of a multi-cycle request
    drive(0, 0, 32'h0, 0, 64'h0);
    cycle();
    #2 reset = 1'b1;
    model_reset();
    #1 chk_reset_outputs("async reset");
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("restart ireq.valid", 64'(ireq.valid), 64'd1);
    chk("restart ireq.addr", ireq.addr, 64'h8000_0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        rp = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rp[63:6] = '1;
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom,
              $urandom_range(0, 19) == 0, rp);
        cycle();
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
